qspi_flash_target: RTL
======================

Name: qspi_flash_target

Overview:
- Quad-SPI flash responder; the target end of the quad-SPI master pad interface (csn/sck/io0..io3).
- Oversamples the SPI pins on sys_clock and decodes read and page-program commands into a simple synchronous memory port.
- Used as the flash-side model and test target in FPGA logic and benches. Supports SPI mode 0 only.

Parameters:
- ADDR_W, 24, address bits captured after the command byte; memory address width.
- DUMMY_CYC, 8, dummy sck cycles for 0x0B and 0x6B.
- PAGE_W, 8, page size = 2^PAGE_W bytes; sets program wrap.

Ports:
- sys_clock  input  1  single clock; sck must be at most sys_clock/4.
- reset  input  1  synchronous, active-high.
- csn  input  1  chip select, active low, asynchronous to sys_clock.
- sck  input  1  SPI clock, asynchronous.
- io_in  input  4  pad inputs {io3, io2, io1, io0}.
- io_out_data  output  4  pad output data.
- io_out_en  output  4  pad output enables.
- mem_addr  output  ADDR_W  memory address.
- mem_rd_en  output  1  read strobe; mem_rdata is valid on the next cycle.
- mem_rdata  input  8  read data.
- mem_wr_en  output  1  one-cycle write strobe.
- mem_wdata  output  8  write data.
- busy  output  1  high while csn is active (synchronised).

Behaviour:
- Synchronisation: csn, sck and io_in each pass through 2-flop synchronisers. The sck rise/fall edge pulses come from the synchronised value and its previous value.
- csn rising (synchronised) in any state:
  - go to IDLE; io_out_en=0 on the next cycle;
  - discard any partial byte; no mem strobe is issued.
- Reset: all outputs 0, state IDLE, counters 0.
- States:
  - IDLE: csn falling -> CMD with bit_cnt=0.
  - CMD: shift io0 on each sck rise, MSB first. On the 8th bit:
    - 0x03 -> ADDR, next READ;
    - 0x0B -> ADDR, next DUMMY then READ;
    - 0x6B -> ADDR, next DUMMY then QREAD;
    - 0x02 -> ADDR, next WRITE;
    - any other opcode -> IGNORE.
  - ADDR: shift io0 for ADDR_W sck rises, MSB first, into addr_reg.
    - On the last rise, pulse mem_rd_en with mem_addr=captured address for read commands.
    - Go to DUMMY or READ/QREAD/WRITE.
  - DUMMY: count DUMMY_CYC sck rises, then enter READ/QREAD. io_out_en stays 0.
  - READ: io_out_en=4'b0010.
    - On each sck fall, io1 drives the next bit of tx_shift, MSB first.
    - tx_shift loads the prefetched byte at the fall that starts a byte.
    - At that same fall, pulse mem_rd_en with addr_reg+1; the result is latched into the prefetch register one cycle later.
  - QREAD: same as READ, with io_out_en=4'b1111. Two falls per byte: high nibble first; io3..io0 = nibble bits 3..0.
  - Read addressing: addr_reg increments per byte and wraps from 2^ADDR_W-1 to 0.
  - Write: on each sck rise, shift io0 in; on the 8th bit:
    - mem_wr_en=1 for one cycle, with mem_wdata=byte and mem_addr=addr_reg;
    - then increment only the low PAGE_W bits (page wrap).
  - IGNORE: all outputs held idle until csn rises.
- First output bit timing:
  - Driven after the first sck fall after ADDR/DUMMY completes.
  - That fall is ≥2 sys_clock cycles after the mem_rd_en that fetched it, so the prefetch is always valid.
- Simultaneous csn rise and sck edge: csn takes priority; the edge is ignored.
- busy = synchronised ~csn.

Optional Feature:
- Macro: QSPI_TARGET_QUAD_EN.
- Defined: 0x6B / QREAD is supported as above.
- Undefined: 0x6B decodes as unknown -> IGNORE; io_out_en[3:2] and [0] are tied 0.

Decomposition:
- Shared package qspi_pkg holds:
  - opcode constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B, CMD_QUAD_READ=8'h6B, CMD_PAGE_PROG=8'h02;
  - state enum {IDLE, CMD, ADDR, DUMMY, READ, QREAD, WRITE, IGNORE}.
- One sub-module: qspi_pin_sync, covering the 2-flop synchronisers for csn/sck/io_in plus the sck rise/fall pulse generator.

Test Plan:
- Single read:
  - Setup: memory[0x000100..0x000103] = A5,3C,F0,0F; sck = sys_clock/8.
  - Stimulus: 0x03, addr 0x000100, 32 sck.
  - Required: io1 serialises A53CF00F MSB first; exactly 4 mem_rd_en pulses plus 1 prefetch; io_out_en=0010.
- Fast read: 0x0B, addr 0x000000, 8 dummy cycles -> io_out_en=0 through the dummies; first data bit appears at the first fall after the 8th dummy rise.
- Quad read (QSPI_TARGET_QUAD_EN defined):
  - Stimulus: 0x6B, addr 0xFFFFFF, read 2 bytes.
  - Required: nibbles of mem[0xFFFFFF] then mem[0x000000] (wrap); io_out_en=1111.
- Page program:
  - Stimulus: 0x02, addr 0x0012FE, 4 data bytes 11,22,33,44.
  - Required: writes to 0x12FE, 0x12FF, 0x1200, 0x1201.
- Abort:
  - csn rises after 5 bits of a write data byte -> no mem_wr_en; io_out_en=0.
  - The next transaction decodes normally.
  - Unknown opcode 0x9F -> no mem strobes; outputs idle until csn high.
- Reset asserted mid-QREAD -> all outputs 0 on the next cycle; state IDLE.

Source files
------------

// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - opcodes and state encoding shared by the quad-SPI flash target
package qspi_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
    localparam logic [7:0] CMD_PAGE_PROG = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        READ,
        QREAD,
        WRITE,
        IGNORE
    } state_t;

endpackage

// File: rtl/qspi_flash_target_if.sv
// rtl/qspi_flash_target_if.sv - pad pins and memory port of the quad-SPI flash target
interface qspi_flash_target_if #(
    parameter int ADDR_W = 24
);
    logic              csn;
    logic              sck;
    logic [3:0]        io_in;
    logic [3:0]        io_out_data;
    logic [3:0]        io_out_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rdata;
    logic              mem_wr_en;
    logic [7:0]        mem_wdata;

    modport slave (
        input  csn, sck, io_in, mem_rdata,
        output io_out_data, io_out_en, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport master (
        output csn, sck, io_in, mem_rdata,
        input  io_out_data, io_out_en, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/qspi_pin_sync.sv
// rtl/qspi_pin_sync.sv - two-flop synchronisers for csn/sck/io plus csn and sck edge pulses
module qspi_pin_sync (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       csn,
    input  logic       sck,
    input  logic [3:0] io_in,
    output logic       csn_s,
    output logic       csn_rise,
    output logic       csn_fall,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic [3:0] io_s
);
    logic       csn_m;
    logic       csn_p;
    logic       sck_m;
    logic       sck_s;
    logic       sck_p;
    logic [3:0] io_m;

    // csn resets to the deselected level so no spurious falling edge appears after reset
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            csn_m <= 1'b1;
            csn_s <= 1'b1;
            csn_p <= 1'b1;
            sck_m <= 1'b0;
            sck_s <= 1'b0;
            sck_p <= 1'b0;
            io_m  <= 4'h0;
            io_s  <= 4'h0;
        end else begin
            csn_m <= csn;
            csn_s <= csn_m;
            csn_p <= csn_s;
            sck_m <= sck;
            sck_s <= sck_m;
            sck_p <= sck_s;
            io_m  <= io_in;
            io_s  <= io_m;
        end
    end

    assign csn_rise = csn_s & ~csn_p;
    assign csn_fall = ~csn_s & csn_p;
    assign sck_rise = sck_s & ~sck_p;
    assign sck_fall = ~sck_s & sck_p;

endmodule

// File: rtl/qspi_flash_target.sv
// rtl/qspi_flash_target.sv - quad-SPI flash responder (mode 0); QSPI_TARGET_QUAD_EN enables 0x6B quad read
module qspi_flash_target
    import qspi_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DUMMY_CYC = 8,
    parameter int PAGE_W    = 8
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    qspi_flash_target_if.slave   bus,
    output logic                 busy
);
    localparam int CNT_W = $clog2(ADDR_W + DUMMY_CYC + 8);

    logic       csn_s;
    logic       csn_rise;
    logic       csn_fall;
    logic       sck_rise;
    logic       sck_fall;
    logic [3:0] io_s;

    qspi_pin_sync u_pin_sync (
        .sys_clock (sys_clock),
        .reset     (reset),
        .csn       (bus.csn),
        .sck       (bus.sck),
        .io_in     (bus.io_in),
        .csn_s     (csn_s),
        .csn_rise  (csn_rise),
        .csn_fall  (csn_fall),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .io_s      (io_s)
    );

    state_t            state;
    state_t            state_next;
    state_t            after_addr;
    state_t            cmd_target;
    logic              need_dummy;
    logic              cmd_dummy;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_inc;
    logic [7:0]        shift_in;
    logic [7:0]        tx_shift;
    logic [7:0]        prefetch;
    logic [7:0]        fetched;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_shift;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              rd_pending;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [7:0]        wdata_q;
    logic [3:0]        io_out_q;
    logic              out_en1;
    logic              last_byte_bit;
    logic              last_addr_bit;
    logic              last_dummy;
    logic              unused_io;

    assign rx_byte       = {shift_in[6:0], io_s[0]};
    assign addr_shift    = {addr_reg[ADDR_W-2:0], io_s[0]};
    assign addr_inc      = addr_reg + ADDR_W'(1);
    assign bit_cnt_inc   = bit_cnt + CNT_W'(1);
    assign last_byte_bit = (bit_cnt == CNT_W'(7));
    assign last_addr_bit = (bit_cnt == CNT_W'(ADDR_W - 1));
    assign last_dummy    = (bit_cnt == CNT_W'(DUMMY_CYC - 1));
    assign unused_io     = ^io_s[3:1];

    // A fall can arrive in the very cycle the memory answers, so bypass the prefetch register then
    assign fetched = rd_pending ? bus.mem_rdata : prefetch;

    always_comb begin
        cmd_target = IGNORE;
        cmd_dummy  = 1'b0;
        case (rx_byte)
            CMD_READ:      cmd_target = READ;
            CMD_FAST_READ: begin
                cmd_target = READ;
                cmd_dummy  = 1'b1;
            end
`ifdef QSPI_TARGET_QUAD_EN
            CMD_QUAD_READ: begin
                cmd_target = QREAD;
                cmd_dummy  = 1'b1;
            end
`endif
            CMD_PAGE_PROG: cmd_target = WRITE;
            default:       cmd_target = IGNORE;
        endcase
    end

    always_comb begin
        state_next = state;
        if (csn_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (csn_fall) state_next = CMD;
                CMD:     if (sck_rise && last_byte_bit)
                             state_next = (cmd_target == IGNORE) ? IGNORE : ADDR;
                ADDR:    if (sck_rise && last_addr_bit)
                             state_next = need_dummy ? DUMMY : after_addr;
                DUMMY:   if (sck_rise && last_dummy) state_next = after_addr;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            after_addr <= IDLE;
            need_dummy <= 1'b0;
            bit_cnt    <= '0;
            shift_in   <= 8'h00;
            tx_shift   <= 8'h00;
            prefetch   <= 8'h00;
            addr_reg   <= '0;
            mem_addr_q <= '0;
            rd_pending <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wdata_q    <= 8'h00;
            io_out_q   <= 4'h0;
            out_en1    <= 1'b0;
        end else begin
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_pending <= rd_en_q;
            if (rd_pending) prefetch <= bus.mem_rdata;
            out_en1    <= (state_next == READ) || (state_next == QREAD);

            if (csn_rise) begin
                bit_cnt  <= '0;
                io_out_q <= 4'h0;
            end else begin
                case (state)
                    IDLE: bit_cnt <= '0;
                    CMD: if (sck_rise) begin
                        shift_in <= rx_byte;
                        bit_cnt  <= last_byte_bit ? '0 : bit_cnt_inc;
                        if (last_byte_bit) begin
                            after_addr <= cmd_target;
                            need_dummy <= cmd_dummy;
                        end
                    end
                    ADDR: if (sck_rise) begin
                        addr_reg <= addr_shift;
                        bit_cnt  <= last_addr_bit ? '0 : bit_cnt_inc;
                        if (last_addr_bit && (after_addr != WRITE)) begin
                            rd_en_q    <= 1'b1;
                            mem_addr_q <= addr_shift;
                        end
                    end
                    DUMMY: if (sck_rise) bit_cnt <= last_dummy ? '0 : bit_cnt_inc;
                    READ: if (sck_fall) begin
                        bit_cnt <= last_byte_bit ? '0 : bit_cnt_inc;
                        if (bit_cnt == '0) begin
                            io_out_q[1] <= fetched[7];
                            tx_shift    <= {fetched[6:0], 1'b0};
                            rd_en_q     <= 1'b1;
                            mem_addr_q  <= addr_inc;
                            addr_reg    <= addr_inc;
                        end else begin
                            io_out_q[1] <= tx_shift[7];
                            tx_shift    <= {tx_shift[6:0], 1'b0};
                        end
                    end
`ifdef QSPI_TARGET_QUAD_EN
                    QREAD: if (sck_fall) begin
                        bit_cnt <= (bit_cnt == '0) ? CNT_W'(1) : '0;
                        if (bit_cnt == '0) begin
                            io_out_q   <= fetched[7:4];
                            tx_shift   <= {fetched[3:0], 4'h0};
                            rd_en_q    <= 1'b1;
                            mem_addr_q <= addr_inc;
                            addr_reg   <= addr_inc;
                        end else begin
                            io_out_q   <= tx_shift[7:4];
                        end
                    end
`endif
                    // Programming wraps inside the page: only the low PAGE_W bits advance
                    WRITE: if (sck_rise) begin
                        shift_in <= rx_byte;
                        bit_cnt  <= last_byte_bit ? '0 : bit_cnt_inc;
                        if (last_byte_bit) begin
                            wr_en_q    <= 1'b1;
                            wdata_q    <= rx_byte;
                            mem_addr_q <= addr_reg;
                            addr_reg   <= {addr_reg[ADDR_W-1:PAGE_W],
                                           addr_reg[PAGE_W-1:0] + PAGE_W'(1)};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef QSPI_TARGET_QUAD_EN
    logic out_en4;

    always_ff @(posedge sys_clock) begin
        if (reset) out_en4 <= 1'b0;
        else       out_en4 <= (state_next == QREAD);
    end

    assign bus.io_out_en = {out_en4, out_en4, out_en1, out_en4};
`else
    assign bus.io_out_en = {2'b00, out_en1, 1'b0};
`endif

    assign bus.io_out_data = io_out_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wdata   = wdata_q;
    assign busy            = ~csn_s;

endmodule
